// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store port: one request at a time,
// byte-lane masked stores, extended loads, and a response after WAIT_STATES extra cycles.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memReqValid_i,
    output logic        memReqReady_o,
    input  logic        memWe_i,
    input  logic [31:0] memAddr_i,
    input  logic [31:0] memWdata_i,
    input  logic [2:0]  memType_i,
    output logic        memRespValid_o,
    output logic [31:0] memRdata_o,
    output logic        memErr_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] pend_q, pend_d;
    logic        pend_err_q, pend_err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_array [2**ADDR_WIDTH];

    logic                  accept;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           rd_word;
    logic                  req_err;
    logic [3:0]            byte_en;
    logic [31:0]           wdata_rep;
    logic [31:0]           load_data;

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] t,
                                           input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (t)
            3'b000:  extend = {{24{b[7]}}, b};
            3'b001:  extend = {{16{h[15]}}, h};
            3'b010:  extend = w;
            3'b100:  extend = {24'd0, b};
            3'b101:  extend = {16'd0, h};
            default: extend = 32'd0;
        endcase
    endfunction

    assign accept   = memReqValid_i && (state_q == ST_IDLE);
    assign word_idx = memAddr_i[ADDR_WIDTH+1:2];
    assign rd_word  = mem_array[word_idx];

    // Any misalignment, out-of-range address or illegal type flags the request.
    always_comb begin
        req_err = 1'b0;
        if ((memType_i[1:0] == 2'b01) && memAddr_i[0])
            req_err = 1'b1;
        if ((memType_i == 3'b010) && (memAddr_i[1:0] != 2'b00))
            req_err = 1'b1;
        if ((memAddr_i >> (ADDR_WIDTH + 2)) != 32'd0)
            req_err = 1'b1;
        if ((memType_i == 3'b011) || (memType_i == 3'b110) || (memType_i == 3'b111))
            req_err = 1'b1;
        if (memWe_i && memType_i[2])
            req_err = 1'b1;
    end

    always_comb begin
        case (memType_i[1:0])
            2'b00:   byte_en = 4'b0001 << memAddr_i[1:0];
            2'b01:   byte_en = memAddr_i[1] ? 4'b1100 : 4'b0011;
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
        case (memType_i[1:0])
            2'b00:   wdata_rep = {4{memWdata_i[7:0]}};
            2'b01:   wdata_rep = {2{memWdata_i[15:0]}};
            default: wdata_rep = memWdata_i;
        endcase
        load_data = (memWe_i || req_err) ? 32'd0 : extend(rd_word, memType_i, memAddr_i[1:0]);
    end

    always_ff @(posedge clk) begin
        if (!reset && accept && memWe_i && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i])
                    mem_array[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    // The response registers only change when the FSM enters RESP.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_err_d = pend_err_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    pend_d     = load_data;
                    pend_err_d = req_err;
                    cnt_d      = 3'd0;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_RESP;
                        rdata_d = load_data;
                        err_d   = req_err;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 3'(WAIT_STATES - 1)) begin
                    state_d = ST_RESP;
                    rdata_d = pend_q;
                    err_d   = pend_err_q;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            pend_q     <= 32'd0;
            pend_err_q <= 1'b0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_err_q <= pend_err_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign memReqReady_o  = (state_q == ST_IDLE);
    assign memRespValid_o = (state_q == ST_RESP);
    assign memRdata_o     = rdata_q;
    assign memErr_o       = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench for dmem_responder: one instance with no wait states and one with three,
// expected responses queued at request time and popped when each response pulse appears.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, valid0, we0, rdy0, resp0, err0;
    logic [2:0]  type0;
    logic [31:0] addr0, wdata0, rdata0;

    logic        rst3, valid3, we3, rdy3, resp3, err3;
    logic [2:0]  type3;
    logic [31:0] addr3, wdata3, rdata3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] sb0[$];
    logic [32:0] sb3[$];
    logic [32:0] m_exp0, m_exp3;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(rst0),
        .memReqValid_i(valid0), .memReqReady_o(rdy0), .memWe_i(we0),
        .memAddr_i(addr0), .memWdata_i(wdata0), .memType_i(type0),
        .memRespValid_o(resp0), .memRdata_o(rdata0), .memErr_o(err0)
    );

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(rst3),
        .memReqValid_i(valid3), .memReqReady_o(rdy3), .memWe_i(we3),
        .memAddr_i(addr3), .memWdata_i(wdata3), .memType_i(type3),
        .memRespValid_o(resp3), .memRdata_o(rdata3), .memErr_o(err3)
    );

    // Response monitors: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (resp0 === 1'b1) begin
            n_checks++;
            if (sb0.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL resp0_unexpected: got rdata=%h err=%b, expected no response", rdata0, err0);
            end else begin
                m_exp0 = sb0.pop_front();
                if ({err0, rdata0} !== m_exp0) begin
                    n_fail++;
                    $display("[TB] FAIL resp0_data: got rdata=%h err=%b, expected rdata=%h err=%b",
                             rdata0, err0, m_exp0[31:0], m_exp0[32]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (resp3 === 1'b1) begin
            n_checks++;
            if (sb3.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL resp3_unexpected: got rdata=%h err=%b, expected no response", rdata3, err3);
            end else begin
                m_exp3 = sb3.pop_front();
                if ({err3, rdata3} !== m_exp3) begin
                    n_fail++;
                    $display("[TB] FAIL resp3_data: got rdata=%h err=%b, expected rdata=%h err=%b",
                             rdata3, err3, m_exp3[31:0], m_exp3[32]);
                end
            end
        end
    end

    task automatic do_req0(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
        @(negedge clk);
        n_checks++;
        if (rdy0 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ready0_idle: got %b, expected 1", rdy0);
        end
        valid0 = 1'b1; we0 = we; type0 = typ; addr0 = addr; wdata0 = wdata;
        sb0.push_back({exp_err, exp_rd});
        @(posedge clk);
        #1 valid0 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (resp0 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL resp0_latency: got respValid=%b, expected 1", resp0);
        end
        n_checks++;
        if (rdy0 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ready0_busy: got %b, expected 0", rdy0);
        end
        @(negedge clk);
        n_checks++;
        if (resp0 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL resp0_pulse: got respValid=%b, expected 0", resp0);
        end
        n_checks++;
        if (rdy0 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ready0_return: got %b, expected 1", rdy0);
        end
        n_checks++;
        if ({err0, rdata0} !== {exp_err, exp_rd}) begin
            n_fail++;
            $display("[TB] FAIL rdata0_hold: got rdata=%h err=%b, expected rdata=%h err=%b",
                     rdata0, err0, exp_rd, exp_err);
        end
    endtask

    task automatic do_req3(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
        int cyc;
        @(negedge clk);
        n_checks++;
        if (rdy3 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ready3_idle: got %b, expected 1", rdy3);
        end
        valid3 = 1'b1; we3 = we; type3 = typ; addr3 = addr; wdata3 = wdata;
        sb3.push_back({exp_err, exp_rd});
        @(posedge clk);
        #1 valid3 = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (resp3 !== 1'b1 && cyc < 20);
        n_checks++;
        if (cyc != 4) begin
            n_fail++;
            $display("[TB] FAIL resp3_latency: got %0d cycles, expected 4", cyc);
        end
        @(negedge clk);
        n_checks++;
        if (rdy3 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ready3_return: got %b, expected 1", rdy3);
        end
    endtask

    task automatic test_reset();
        rst0 = 1'b1; valid0 = 1'b0; we0 = 1'b0; type0 = 3'b010; addr0 = '0; wdata0 = '0;
        rst3 = 1'b1; valid3 = 1'b0; we3 = 1'b0; type3 = 3'b010; addr3 = '0; wdata3 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({rdy0, resp0, err0, rdata0} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("[TB] FAIL reset0: got ready=%b resp=%b err=%b rdata=%h, expected 1 0 0 00000000",
                     rdy0, resp0, err0, rdata0);
        end
        n_checks++;
        if ({rdy3, resp3, err3, rdata3} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("[TB] FAIL reset3: got ready=%b resp=%b err=%b rdata=%h, expected 1 0 0 00000000",
                     rdy3, resp3, err3, rdata3);
        end
        rst0 = 1'b0;
        rst3 = 1'b0;
    endtask

    task automatic test_word();
        do_req0(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        do_req0(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        do_req0(1'b1, 3'b010, 32'hFFC, 32'h0BADF00D, 32'h0, 1'b0);
        do_req0(1'b0, 3'b010, 32'hFFC, 32'h0, 32'h0BADF00D, 1'b0);
    endtask

    task automatic test_byte();
        do_req0(1'b1, 3'b000, 32'h13, 32'h00000080, 32'h0, 1'b0);
        do_req0(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
        do_req0(1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0);
        do_req0(1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
        do_req0(1'b0, 3'b100, 32'h11, 32'h0, 32'h000000BE, 1'b0);
    endtask

    task automatic test_half();
        do_req0(1'b1, 3'b001, 32'h12, 32'h12348001, 32'h0, 1'b0);
        do_req0(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8001, 1'b0);
        do_req0(1'b0, 3'b101, 32'h12, 32'h0, 32'h00008001, 1'b0);
        do_req0(1'b0, 3'b010, 32'h10, 32'h0, 32'h8001BEEF, 1'b0);
        do_req0(1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
    endtask

    task automatic test_errors();
        do_req0(1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1);
        do_req0(1'b1, 3'b001, 32'h11, 32'hFFFFFFFF, 32'h0, 1'b1);
        do_req0(1'b0, 3'b010, 32'h10, 32'h0, 32'h8001BEEF, 1'b0);
        do_req0(1'b0, 3'b010, 32'h00001000, 32'h0, 32'h0, 1'b1);
        do_req0(1'b1, 3'b010, 32'h00001010, 32'h55555555, 32'h0, 1'b1);
        do_req0(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
        do_req0(1'b1, 3'b100, 32'h10, 32'h000000AA, 32'h0, 1'b1);
        do_req0(1'b0, 3'b010, 32'h10, 32'h0, 32'h8001BEEF, 1'b0);
    endtask

    task automatic test_wait_states();
        logic exp_v;
        @(negedge clk);
        valid3 = 1'b1; we3 = 1'b1; type3 = 3'b010; addr3 = 32'h20; wdata3 = 32'hCAFEF00D;
        sb3.push_back({1'b0, 32'h0});
        @(posedge clk);
        // Valid stays high through the busy window; a second accept would surface as an extra response.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_v = (k == 3);
            n_checks++;
            if (rdy3 !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL ready3_busy: cycle %0d got %b, expected 0", k + 1, rdy3);
            end
            n_checks++;
            if (resp3 !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL resp3_timing: cycle %0d got %b, expected %b", k + 1, resp3, exp_v);
            end
            if (k == 3)
                valid3 = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (rdy3 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ready3_after_resp: got %b, expected 1", rdy3);
        end
        do_req3(1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);
    endtask

    task automatic test_reset_in_wait();
        int seen;
        @(negedge clk);
        valid3 = 1'b1; we3 = 1'b0; type3 = 3'b010; addr3 = 32'h20; wdata3 = 32'h0;
        @(posedge clk);
        #1 valid3 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst3 = 1'b1;
        valid3 = 1'b1; we3 = 1'b1; type3 = 3'b010; addr3 = 32'h20; wdata3 = 32'h11111111;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({rdy3, resp3, err3, rdata3} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("[TB] FAIL reset3_in_wait: got ready=%b resp=%b err=%b rdata=%h, expected 1 0 0 00000000",
                     rdy3, resp3, err3, rdata3);
        end
        rst3 = 1'b0;
        valid3 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rdy3 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ready3_after_reset: got %b, expected 1", rdy3);
        end
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp3 === 1'b1)
                seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("[TB] FAIL resp3_dropped: got %0d pulses, expected 0", seen);
        end
        do_req3(1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);
        do_req3(1'b0, 3'b101, 32'h21, 32'h0, 32'h0, 1'b1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_wait_states();
        test_reset_in_wait();
        repeat (2) @(negedge clk);
        n_checks++;
        if (sb0.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL sb0_drain: got %0d pending, expected 0", sb0.size());
        end
        n_checks++;
        if (sb3.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL sb3_drain: got %0d pending, expected 0", sb3.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
